// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I pipeline control path: opcodes, operand
// select encodings and the decoded control bundle carried between stages.
package rv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [1:0] ALU1_RS1  = 2'b00;
  localparam logic [1:0] ALU1_ZERO = 2'b01;
  localparam logic [1:0] ALU1_PC   = 2'b10;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXM = 2'b10;
  localparam logic [1:0] FWD_MWB = 2'b01;

  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu2_src;
    logic       reg_write;
    logic       auipc;
    logic [1:0] alu1_src;
  } ctrl_t;

  // The younger producer (EX/MEM) shadows the older one (MEM/WB).
  function automatic logic [1:0] fwd_pick(input logic exm_hit, input logic mwb_hit);
    return exm_hit ? FWD_EXM : (mwb_hit ? FWD_MWB : FWD_RF);
  endfunction

endpackage

// File: rtl/rv_ctrl_pipe_if.sv
// Datapath <-> control-pipe signal bundle; the datapath is the master.
interface rv_ctrl_pipe_if #(parameter int REG_AW = 5);

  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs1_i, id_rs2_i, id_rd_i;
  logic              id_branch_i, id_mem_read_i, id_mem_to_reg_i, id_mem_write_i;
  logic              id_alu2_src_i, id_reg_write_i, id_auipc_i;
  logic [1:0]        id_alu1_src_i, id_reg_read_i;
  logic              ex_branch_taken_i;

  logic              stall_o, flush_o;
  logic              ex_valid_o, ex_branch_o, ex_alu2_src_o, ex_auipc_o;
  logic [1:0]        ex_alu1_src_o;
  logic              mem_valid_o, mem_read_o, mem_write_o;
  logic              wb_valid_o, wb_reg_write_o, wb_mem_to_reg_o;
  logic [REG_AW-1:0] wb_rd_o;
  logic [1:0]        fwd_a_o, fwd_b_o;

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_branch_i, id_mem_read_i,
           id_mem_to_reg_i, id_mem_write_i, id_alu2_src_i, id_reg_write_i, id_auipc_i,
           id_alu1_src_i, id_reg_read_i, ex_branch_taken_i,
    input  stall_o, flush_o, ex_valid_o, ex_branch_o, ex_alu2_src_o, ex_auipc_o,
           ex_alu1_src_o, mem_valid_o, mem_read_o, mem_write_o, wb_valid_o,
           wb_reg_write_o, wb_mem_to_reg_o, wb_rd_o, fwd_a_o, fwd_b_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_branch_i, id_mem_read_i,
           id_mem_to_reg_i, id_mem_write_i, id_alu2_src_i, id_reg_write_i, id_auipc_i,
           id_alu1_src_i, id_reg_read_i, ex_branch_taken_i,
    output stall_o, flush_o, ex_valid_o, ex_branch_o, ex_alu2_src_o, ex_auipc_o,
           ex_alu1_src_o, mem_valid_o, mem_read_o, mem_write_o, wb_valid_o,
           wb_reg_write_o, wb_mem_to_reg_o, wb_rd_o, fwd_a_o, fwd_b_o
  );

endinterface

// File: rtl/rv_stage_reg.sv
// One pipeline boundary: valid bit plus an opaque bundle. An invalid or
// bubbled input loads all-zero so downstream controls are inert.
module rv_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_bubble,
  input  logic         i_vld,
  input  logic [W-1:0] i_d,
  output logic         o_vld,
  output logic [W-1:0] o_q
);

  logic         r_vld;
  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= 1'b0;
      r_q   <= '0;
    end else if (i_bubble || !i_vld) begin
      r_vld <= 1'b0;
      r_q   <= '0;
    end else begin
      r_vld <= 1'b1;
      r_q   <= i_d;
    end
  end

  assign o_vld = r_vld;
  assign o_q   = r_q;

endmodule

// File: rtl/rv_ctrl_pipe.sv
// Control bundle carrier ID->EX->MEM->WB with load-use stall, taken-branch
// flush and EX operand forwarding selects.
module rv_ctrl_pipe
  import rv_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input logic          clk,
  input logic          rst,
  rv_ctrl_pipe_if.slave bus
);

  typedef struct packed {
    ctrl_t             c;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [1:0]        rr;
  } stage_t;

  localparam int SW = $bits(stage_t);

  stage_t w_id, w_ex, w_mem, w_wb;
  logic   w_ex_v, w_mem_v, w_wb_v;
  logic   w_hazard, w_flush, w_bubble;
  logic   w_mem_fwd, w_wb_fwd;
  logic   w_unused;

  assign w_id.c.branch     = bus.id_branch_i;
  assign w_id.c.mem_read   = bus.id_mem_read_i;
  assign w_id.c.mem_to_reg = bus.id_mem_to_reg_i;
  assign w_id.c.mem_write  = bus.id_mem_write_i;
  assign w_id.c.alu2_src   = bus.id_alu2_src_i;
  assign w_id.c.reg_write  = bus.id_reg_write_i;
  assign w_id.c.auipc      = bus.id_auipc_i;
  assign w_id.c.alu1_src   = bus.id_alu1_src_i;
  assign w_id.rs1          = bus.id_rs1_i;
  assign w_id.rs2          = bus.id_rs2_i;
  assign w_id.rd           = bus.id_rd_i;
  assign w_id.rr           = bus.id_reg_read_i;

  rv_stage_reg #(.W(SW)) u_ex (
    .clk(clk), .rst(rst), .i_bubble(w_bubble), .i_vld(bus.id_valid_i),
    .i_d(w_id), .o_vld(w_ex_v), .o_q(w_ex));

  rv_stage_reg #(.W(SW)) u_mem (
    .clk(clk), .rst(rst), .i_bubble(1'b0), .i_vld(w_ex_v),
    .i_d(w_ex), .o_vld(w_mem_v), .o_q(w_mem));

  rv_stage_reg #(.W(SW)) u_wb (
    .clk(clk), .rst(rst), .i_bubble(1'b0), .i_vld(w_mem_v),
    .i_d(w_mem), .o_vld(w_wb_v), .o_q(w_wb));

  // A load in EX whose rd is read at ID cannot be forwarded in time.
  assign w_hazard = w_ex_v & w_ex.c.mem_read & (w_ex.rd != '0) & bus.id_valid_i &
                    ((bus.id_reg_read_i[0] & (bus.id_rs1_i == w_ex.rd)) |
                     (bus.id_reg_read_i[1] & (bus.id_rs2_i == w_ex.rd)));
  assign w_flush  = w_ex_v & w_ex.c.branch & bus.ex_branch_taken_i;
  assign w_bubble = w_hazard | w_flush;

  assign bus.stall_o = w_hazard & ~w_flush;
  assign bus.flush_o = w_flush;

  // Load data is not ready in EX/MEM, so only ALU results forward from there.
  assign w_mem_fwd = w_mem_v & w_mem.c.reg_write & ~w_mem.c.mem_to_reg & (w_mem.rd != '0);
  assign w_wb_fwd  = w_wb_v & w_wb.c.reg_write & (w_wb.rd != '0);

  assign bus.fwd_a_o = fwd_pick(w_ex_v & w_ex.rr[0] & w_mem_fwd & (w_mem.rd == w_ex.rs1),
                                w_ex_v & w_ex.rr[0] & w_wb_fwd  & (w_wb.rd  == w_ex.rs1));
  assign bus.fwd_b_o = fwd_pick(w_ex_v & w_ex.rr[1] & w_mem_fwd & (w_mem.rd == w_ex.rs2),
                                w_ex_v & w_ex.rr[1] & w_wb_fwd  & (w_wb.rd  == w_ex.rs2));

  assign bus.ex_valid_o      = w_ex_v;
  assign bus.ex_branch_o     = w_ex_v & w_ex.c.branch;
  assign bus.ex_alu2_src_o   = w_ex_v & w_ex.c.alu2_src;
  assign bus.ex_auipc_o      = w_ex_v & w_ex.c.auipc;
  assign bus.ex_alu1_src_o   = w_ex_v ? w_ex.c.alu1_src : 2'b00;
  assign bus.mem_valid_o     = w_mem_v;
  assign bus.mem_read_o      = w_mem_v & w_mem.c.mem_read;
  assign bus.mem_write_o     = w_mem_v & w_mem.c.mem_write;
  assign bus.wb_valid_o      = w_wb_v;
  assign bus.wb_reg_write_o  = w_wb_v & w_wb.c.reg_write;
  assign bus.wb_mem_to_reg_o = w_wb_v & w_wb.c.mem_to_reg;
  assign bus.wb_rd_o         = w_wb_v ? w_wb.rd : '0;

  // WB keeps the full bundle for debug visibility; most of it has no consumer.
  assign w_unused = ^w_wb;

endmodule

// File: tb/tb_rv_ctrl_pipe.sv
// Bench for rv_ctrl_pipe: reset sequences, a hand-derived hazard table and
// randomized traffic checked against an instruction-level pipeline model.
module tb_rv_ctrl_pipe;
  import rv_pkg::*;

  typedef struct packed {
    logic v, br, mr, m2r, mw, a2, rw, au;
    logic [1:0] a1, rr;
    logic [4:0] rs1, rs2, rd;
  } ins_t;

  typedef struct {
    ins_t       id;
    logic       tk;
    logic       stall, flush;
    logic [1:0] fa, fb;
    logic       exv;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   errs = 0;
  int   checks = 0;
  ins_t m_ex, m_mem, m_wb;
  vec_t tbl[20];

  always #5 clk = ~clk;

  rv_ctrl_pipe_if #(.REG_AW(5)) bus ();
  rv_ctrl_pipe #(.REG_AW(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic ins_t i_lw(logic [4:0] rd, logic [4:0] rs1);
    ins_t t = '0;
    t.v = 1'b1; t.mr = 1'b1; t.m2r = 1'b1; t.rw = 1'b1; t.a2 = 1'b1;
    t.rr = 2'b01; t.rd = rd; t.rs1 = rs1;
    return t;
  endfunction

  function automatic ins_t i_alu(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    ins_t t = '0;
    t.v = 1'b1; t.rw = 1'b1; t.rr = 2'b11; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
    return t;
  endfunction

  function automatic ins_t i_addi(logic [4:0] rd, logic [4:0] rs1);
    ins_t t = '0;
    t.v = 1'b1; t.rw = 1'b1; t.a2 = 1'b1; t.rr = 2'b01; t.rd = rd; t.rs1 = rs1;
    return t;
  endfunction

  function automatic ins_t i_beq(logic [4:0] rs1, logic [4:0] rs2);
    ins_t t = '0;
    t.v = 1'b1; t.br = 1'b1; t.rr = 2'b11; t.rs1 = rs1; t.rs2 = rs2;
    return t;
  endfunction

  function automatic vec_t mkv(ins_t id, logic tk, logic st, logic fl,
                               logic [1:0] fa, logic [1:0] fb, logic exv);
    vec_t r;
    r.id = id; r.tk = tk; r.stall = st; r.flush = fl; r.fa = fa; r.fb = fb; r.exv = exv;
    return r;
  endfunction

  function automatic ins_t rnd_ins();
    logic [31:0] r;
    ins_t t;
    r = $urandom;
    t = r[$bits(ins_t)-1:0];
    t.v   = ($urandom_range(0, 4) != 0);
    t.rs1 = 5'($urandom_range(0, 3));
    t.rs2 = 5'($urandom_range(0, 3));
    t.rd  = 5'($urandom_range(0, 3));
    return t;
  endfunction

  task automatic drive(ins_t t, logic tk);
    bus.id_valid_i        = t.v;
    bus.id_branch_i       = t.br;
    bus.id_mem_read_i     = t.mr;
    bus.id_mem_to_reg_i   = t.m2r;
    bus.id_mem_write_i    = t.mw;
    bus.id_alu2_src_i     = t.a2;
    bus.id_reg_write_i    = t.rw;
    bus.id_auipc_i        = t.au;
    bus.id_alu1_src_i     = t.a1;
    bus.id_reg_read_i     = t.rr;
    bus.id_rs1_i          = t.rs1;
    bus.id_rs2_i          = t.rs2;
    bus.id_rd_i           = t.rd;
    bus.ex_branch_taken_i = tk;
  endtask

  function automatic logic [22:0] dut_word();
    return {bus.stall_o, bus.flush_o, bus.ex_valid_o, bus.ex_branch_o, bus.ex_alu2_src_o,
            bus.ex_auipc_o, bus.ex_alu1_src_o, bus.mem_valid_o, bus.mem_read_o,
            bus.mem_write_o, bus.wb_valid_o, bus.wb_reg_write_o, bus.wb_mem_to_reg_o,
            bus.wb_rd_o, bus.fwd_a_o, bus.fwd_b_o};
  endfunction

  // Reference: m_ex/m_mem/m_wb hold whole instructions (all-zero = empty slot).
  function automatic logic m_flush(logic tk);
    return m_ex.v && m_ex.br && tk;
  endfunction

  function automatic logic m_stall(ins_t t, logic tk);
    logic uses;
    uses = (t.rr[0] && t.rs1 == m_ex.rd) || (t.rr[1] && t.rs2 == m_ex.rd);
    return m_ex.v && m_ex.mr && m_ex.rd != 0 && t.v && uses && !m_flush(tk);
  endfunction

  function automatic logic [1:0] m_fwd(logic reads, logic [4:0] src);
    if (!m_ex.v || !reads || src == 0) return FWD_RF;
    if (m_mem.v && m_mem.rw && !m_mem.m2r && m_mem.rd == src) return FWD_EXM;
    if (m_wb.v && m_wb.rw && m_wb.rd == src) return FWD_MWB;
    return FWD_RF;
  endfunction

  function automatic logic [22:0] m_word(ins_t t, logic tk);
    return {m_stall(t, tk), m_flush(tk), m_ex.v, m_ex.v & m_ex.br, m_ex.v & m_ex.a2,
            m_ex.v & m_ex.au, (m_ex.v ? m_ex.a1 : 2'b00), m_mem.v, m_mem.v & m_mem.mr,
            m_mem.v & m_mem.mw, m_wb.v, m_wb.v & m_wb.rw, m_wb.v & m_wb.m2r,
            (m_wb.v ? m_wb.rd : 5'd0), m_fwd(m_ex.rr[0], m_ex.rs1), m_fwd(m_ex.rr[1], m_ex.rs2)};
  endfunction

  task automatic m_adv(ins_t t, logic tk);
    logic take;
    take  = t.v && !m_stall(t, tk) && !m_flush(tk) && !(m_ex.v && m_ex.mr && m_ex.rd != 0 && t.v &&
            ((t.rr[0] && t.rs1 == m_ex.rd) || (t.rr[1] && t.rs2 == m_ex.rd)));
    m_wb  = m_mem;
    m_mem = m_ex;
    m_ex  = take ? t : '0;
  endtask

  task automatic m_clear();
    m_ex = '0; m_mem = '0; m_wb = '0;
  endtask

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s[%0d] got %h expected %h", nm, idx, act, exp);
    end
  endtask

  // Entered just after a rising edge; leaves just after the next one.
  task automatic step(ins_t t, logic tk, int idx);
    drive(t, tk);
    #1;
    chk("rand", idx, 32'(dut_word()), 32'(m_word(t, tk)));
    @(posedge clk);
    m_adv(t, tk);
    #1;
  endtask

  initial begin
    // lw x5 / add x6,x5,x7 stall; add x3 / sub x4,x3,x3 fwd; beq flush;
    // flush-vs-stall priority; x0 cases; double producer of x9.
    tbl[0]  = mkv(i_lw(5'd5, 5'd1),            1'b0, 1'b0, 1'b0, FWD_RF,  FWD_RF,  1'b0);
    tbl[1]  = mkv(i_alu(5'd6, 5'd5, 5'd7),     1'b0, 1'b1, 1'b0, FWD_RF,  FWD_RF,  1'b1);
    tbl[2]  = mkv(i_alu(5'd6, 5'd5, 5'd7),     1'b0, 1'b0, 1'b0, FWD_RF,  FWD_RF,  1'b0);
    tbl[3]  = mkv(i_alu(5'd3, 5'd1, 5'd2),     1'b0, 1'b0, 1'b0, FWD_MWB, FWD_RF,  1'b1);
    tbl[4]  = mkv(i_alu(5'd4, 5'd3, 5'd3),     1'b0, 1'b0, 1'b0, FWD_RF,  FWD_RF,  1'b1);
    tbl[5]  = mkv('0,                          1'b0, 1'b0, 1'b0, FWD_EXM, FWD_EXM, 1'b1);
    tbl[6]  = mkv(i_beq(5'd4, 5'd3),           1'b0, 1'b0, 1'b0, FWD_RF,  FWD_RF,  1'b0);
    tbl[7]  = mkv(i_alu(5'd8, 5'd1, 5'd2),     1'b1, 1'b0, 1'b1, FWD_MWB, FWD_RF,  1'b1);
    tbl[8]  = mkv('0,                          1'b1, 1'b0, 1'b0, FWD_RF,  FWD_RF,  1'b0);
    tbl[9]  = mkv('0,                          1'b0, 1'b0, 1'b0, FWD_RF,  FWD_RF,  1'b0);
    tbl[10] = mkv(i_alu(5'd11, 5'd10, 5'd10),  1'b1, 1'b0, 1'b1, FWD_RF,  FWD_RF,  1'b1);
    tbl[11] = mkv(i_alu(5'd11, 5'd10, 5'd10),  1'b0, 1'b0, 1'b0, FWD_RF,  FWD_RF,  1'b0);
    tbl[12] = mkv(i_alu(5'd0, 5'd1, 5'd1),     1'b0, 1'b0, 1'b0, FWD_MWB, FWD_MWB, 1'b1);
    tbl[13] = mkv(i_alu(5'd12, 5'd0, 5'd0),    1'b0, 1'b0, 1'b0, FWD_RF,  FWD_RF,  1'b1);
    tbl[14] = mkv(i_lw(5'd0, 5'd3),            1'b0, 1'b0, 1'b0, FWD_RF,  FWD_RF,  1'b1);
    tbl[15] = mkv(i_alu(5'd13, 5'd0, 5'd0),    1'b0, 1'b0, 1'b0, FWD_RF,  FWD_RF,  1'b1);
    tbl[16] = mkv(i_addi(5'd9, 5'd1),          1'b0, 1'b0, 1'b0, FWD_RF,  FWD_RF,  1'b1);
    tbl[17] = mkv(i_addi(5'd9, 5'd2),          1'b0, 1'b0, 1'b0, FWD_RF,  FWD_RF,  1'b1);
    tbl[18] = mkv(i_alu(5'd14, 5'd9, 5'd0),    1'b0, 1'b0, 1'b0, FWD_RF,  FWD_RF,  1'b1);
    tbl[19] = mkv('0,                          1'b0, 1'b0, 1'b0, FWD_EXM, FWD_RF,  1'b1);
    // Slot 9 drives a fabricated branch+load so the flush/stall overlap is real.
    tbl[9].id     = i_lw(5'd10, 5'd0);
    tbl[9].id.br  = 1'b1;

    // Reset held with a valid instruction at ID.
    rst = 1'b1;
    drive(i_lw(5'd5, 5'd1), 1'b0);
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold", 0, 32'(dut_word()), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold", 1, 32'(dut_word()), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_release_exv", 0, 32'(bus.ex_valid_o), 32'd1);
    chk("rst_release_wbv", 0, 32'(bus.wb_valid_o), 32'd0);

    // Asynchronous clear between edges, then the directed table.
    rst = 1'b1;
    #1;
    chk("rst_async_exv", 0, 32'(bus.ex_valid_o), 32'd0);
    rst = 1'b0;
    m_clear();
    for (int k = 0; k < 20; k++) begin
      drive(tbl[k].id, tbl[k].tk);
      #1;
      chk("vec", k, 32'({bus.stall_o, bus.flush_o, bus.fwd_a_o, bus.fwd_b_o, bus.ex_valid_o}),
          32'({tbl[k].stall, tbl[k].flush, tbl[k].fa, tbl[k].fb, tbl[k].exv}));
      chk("vec_model", k, 32'(dut_word()), 32'(m_word(tbl[k].id, tbl[k].tk)));
      @(posedge clk);
      m_adv(tbl[k].id, tbl[k].tk);
      #1;
    end

    // Randomized traffic with a reset dropped in mid-stream.
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        drive(i_lw(5'd1, 5'd2), 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_mid", 0, 32'(dut_word()), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_mid", 1, 32'(dut_word()), 32'd0);
        rst = 1'b0;
        m_clear();
        step(i_lw(5'd1, 5'd2), 1'b0, n);
        chk("rst_mid_exv", 0, 32'(bus.ex_valid_o), 32'd1);
      end
      step(rnd_ins(), 1'($urandom_range(0, 1)), n);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
